bram_frame_fetcher: RTL and testbench
=====================================

Name: bram_frame_fetcher

Overview:
- Parametrised successor of the single-frame BRAM read controller.
- Streams a full IMG_ROWS x IMG_COLS frame from a read-only BRAM of configurable read latency into a valid/ready pixel stream for preprocess.
- Tracks in-flight reads with credits and a small output FIFO, so downstream backpressure never loses data.
- Supports start/done/abort handshakes and row/column tagging of every output pixel.

Parameters:
- DATA_W, 8, pixel/BRAM data width.
- ADDR_W, 19, BRAM address width.
- IMG_ROWS, 540, rows per frame.
- IMG_COLS, 540, columns per frame.
- RD_LAT, 2, BRAM read latency in clocks; legal range 1..4.
- FIFO_DEPTH, 4, output FIFO entries; must be >= RD_LAT+1 and a power of 2.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, synchronous active-low reset.
- start_i, input, 1, one-cycle pulse; begin a frame (honoured in IDLE only).
- abort_i, input, 1, one-cycle pulse; cancel the current frame.
- base_addr_i, input, ADDR_W, frame base address; latched on accepted start.
- busy_o, output, 1, high from accepted start until return to IDLE.
- done_o, output, 1, one-cycle pulse after the last pixel handshake.
- ena_o, output, 1, BRAM enable, high only on read-issue cycles.
- wea_o, output, 1, tied 0.
- addr_o, output, ADDR_W, BRAM read address.
- d2mem_o, output, DATA_W, tied 0.
- mem2d_i, input, DATA_W, BRAM read data.
- m_valid_o, output, 1, output pixel valid.
- m_ready_i, input, 1, downstream ready.
- m_data_o, output, DATA_W, pixel.
- m_row_o, output, $clog2(IMG_ROWS), row of the current output pixel.
- m_col_o, output, $clog2(IMG_COLS), column of the current output pixel.
- m_eol_o, output, 1, current pixel is col IMG_COLS-1.
- m_last_o, output, 1, current pixel is the frame's last.

Behaviour:
- Reset values: all outputs 0; state IDLE; FIFO empty; latency pipe cleared; counters 0.
- States: IDLE, FETCH, WAIT, FLUSH.
  - IDLE: start_i -> FETCH. Latch base_addr_i; issue counter = 0; busy_o = 1.
  - FETCH: issue a read (ena_o=1, addr_o = base + issue count) when credits > 0. After issue of read IMG_ROWS*IMG_COLS-1 -> WAIT.
  - WAIT: no issues. Output handshake of the last pixel -> IDLE with done_o pulsed that same cycle edge (done_o high for the cycle after the last handshake).
  - FLUSH: entered on abort_i in FETCH/WAIT. No issues; FIFO emptied; m_valid_o = 0; BRAM returns discarded. After RD_LAT cycles -> IDLE. No done_o.
- Credits: credits = FIFO_DEPTH - fifo_count - inflight. Issue only when credits >= 1, accounting for a same-cycle pop.
- Latency: a read issued in cycle t lands in the FIFO at the end of cycle t+RD_LAT. Tracking uses an RD_LAT-deep valid shift register.
- Throughput: with m_ready_i held 1, one pixel per clock. First m_valid_o is RD_LAT+1 cycles after the start cycle.
- FIFO: first-word-fall-through; m_data_o/m_valid_o driven from the head. Pop on m_valid_o & m_ready_i. Simultaneous push and pop at full is legal. Overflow is impossible by construction; the bench asserts this.
- Output counters: m_col_o advances on each handshake; wraps IMG_COLS-1 -> 0 and increments m_row_o. After the last pixel both return to 0.
- m_valid_o must stay asserted with stable data until accepted.
- start_i while busy_o: ignored. abort_i in IDLE: ignored. abort_i and start_i together in IDLE: start wins.
- abort_i in the same cycle as the final handshake: the final handshake completes, done_o pulses, and the abort is ignored.
- Address arithmetic: modulo 2^ADDR_W; wrap is not flagged.
- rst_n low mid-frame: immediate return to reset values; in-flight data dropped.

Optional Feature:
- Macro FETCH_STALL_CNT_EN.
- Defined: adds output stall_cnt_o, 32 bits. It counts cycles with m_valid_o=1 & m_ready_i=0 within the current frame, clears on accepted start, saturates at 0xFFFFFFFF, and holds after done_o.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- IMG_ROWS=3, IMG_COLS=4, RD_LAT=2, base=0x100, BRAM holds addr[7:0], m_ready_i=1:
  - 12 pixels 0x00..0x0B on consecutive cycles; first valid 3 cycles after start.
  - m_eol_o on cols 3; m_last_o on the 12th pixel; done_o 1 cycle later.
- Same setup, m_ready_i toggling 1/0 each cycle: same 12 values in order, none dropped or duplicated. Data stays stable while stalled. ena_o never issues with credits 0. With FETCH_STALL_CNT_EN, stall_cnt_o = 11 (or the bench's counted value) at done_o.
- RD_LAT=4, FIFO_DEPTH=8, m_ready_i=0 for 20 cycles after start: exactly 8 ena_o pulses. Then ready=1 -> full frame completes correctly.
- abort_i at the 5th issue: busy_o drops after RD_LAT FLUSH cycles; no done_o; m_valid_o 0 during FLUSH. A following start gives a complete fresh frame starting at pixel (0,0).
- start_i pulsed again mid-frame, and abort_i pulsed in IDLE: both ignored; frame output unchanged.
- rst_n low for 1 cycle mid-frame: all outputs 0 next cycle. A new start then gives a correct full frame.

Source files
------------

// File: rtl/bram_frame_fetcher.sv
// Streams an IMG_ROWS x IMG_COLS frame from a read-only BRAM with RD_LAT read latency into a
// row/col-tagged valid/ready pixel stream. Define FETCH_STALL_CNT_EN to add the per-frame stall counter.
module bram_frame_fetcher #(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned ADDR_W     = 19,
   parameter int unsigned IMG_ROWS   = 540,
   parameter int unsigned IMG_COLS   = 540,
   parameter int unsigned RD_LAT     = 2,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start_i,
   input  logic                        abort_i,
   input  logic [ADDR_W-1:0]           base_addr_i,
   output logic                        busy_o,
   output logic                        done_o,
   output logic                        ena_o,
   output logic                        wea_o,
   output logic [ADDR_W-1:0]           addr_o,
   output logic [DATA_W-1:0]           d2mem_o,
   input  logic [DATA_W-1:0]           mem2d_i,
   output logic                        m_valid_o,
   input  logic                        m_ready_i,
   output logic [DATA_W-1:0]           m_data_o,
   output logic [$clog2(IMG_ROWS)-1:0] m_row_o,
   output logic [$clog2(IMG_COLS)-1:0] m_col_o,
   output logic                        m_eol_o,
   output logic                        m_last_o
`ifdef FETCH_STALL_CNT_EN
   ,
   output logic [31:0]                 stall_cnt_o
`endif
);

   localparam int unsigned TOTAL  = IMG_ROWS * IMG_COLS;
   localparam int unsigned CNT_W  = $clog2(TOTAL + 1);
   localparam int unsigned ROW_W  = $clog2(IMG_ROWS);
   localparam int unsigned COL_W  = $clog2(IMG_COLS);
   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned FCNT_W = PTR_W + 1;
   localparam int unsigned OCC_W  = PTR_W + 2;
   localparam int unsigned FL_W   = $clog2(RD_LAT) + 1;

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_FLUSH} state_t;

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   base_q;
   logic [CNT_W-1:0]    issue_cnt;
   logic [RD_LAT-1:0]   vpipe;
   logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr, rd_ptr;
   logic [FCNT_W-1:0]   fifo_cnt;
   logic [ROW_W-1:0]    row_q;
   logic [COL_W-1:0]    col_q;
   logic [FL_W-1:0]     flush_cnt;
   logic [OCC_W-1:0]    occ;
   logic                start_acc, in_frame, flush_req, issue, can_issue;
   logic                push, pop, last_pix, last_hs, col_end;

   assign start_acc = (state == S_IDLE) && start_i;
   assign in_frame  = (state == S_FETCH) || (state == S_WAIT);
   assign m_valid_o = (fifo_cnt != '0);
   assign m_data_o  = m_valid_o ? fifo_mem[rd_ptr] : '0;
   assign pop       = m_valid_o && m_ready_i;
   assign push      = vpipe[RD_LAT-1] && in_frame;
   assign col_end   = (col_q == COL_W'(IMG_COLS - 1));
   assign last_pix  = col_end && (row_q == ROW_W'(IMG_ROWS - 1));
   assign last_hs   = pop && last_pix;
   // A final handshake outranks a coincident abort.
   assign flush_req = in_frame && abort_i && !last_hs;
   assign m_eol_o   = m_valid_o && col_end;
   assign m_last_o  = m_valid_o && last_pix;
   assign m_row_o   = row_q;
   assign m_col_o   = col_q;

   // Reads in flight plus buffered pixels, less the one leaving this cycle, must leave a free slot.
   assign occ       = OCC_W'(fifo_cnt) + OCC_W'($countones(vpipe)) - OCC_W'(pop);
   assign can_issue = (occ < OCC_W'(FIFO_DEPTH));

   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:  if (start_i) state_nxt = (TOTAL == 1) ? S_WAIT : S_FETCH;
         S_FETCH: begin
            if (flush_req)                                   state_nxt = S_FLUSH;
            else if (issue && issue_cnt == CNT_W'(TOTAL - 1)) state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (last_hs)      state_nxt = S_IDLE;
            else if (abort_i) state_nxt = S_FLUSH;
         end
         S_FLUSH: if (flush_cnt == FL_W'(RD_LAT - 1)) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // The first read goes out in the start cycle itself, addressed straight from base_addr_i.
   always_comb begin
      issue   = 1'b0;
      addr_o  = '0;
      busy_o  = (state != S_IDLE);
      wea_o   = 1'b0;
      d2mem_o = '0;
      unique case (state)
         S_IDLE: begin
            issue = start_i;
            if (start_i) addr_o = base_addr_i;
         end
         S_FETCH: begin
            issue = can_issue;
            if (can_issue) addr_o = base_q + ADDR_W'(issue_cnt);
         end
         default: issue = 1'b0;
      endcase
      ena_o = issue;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         base_q    <= '0;
         issue_cnt <= '0;
         vpipe     <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         fifo_cnt  <= '0;
         row_q     <= '0;
         col_q     <= '0;
         flush_cnt <= '0;
         done_o    <= 1'b0;
      end else begin
         done_o   <= (state == S_WAIT) && last_hs;
         vpipe[0] <= issue;
         for (int unsigned i = 1; i < RD_LAT; i++) vpipe[i] <= vpipe[i-1];

         if (start_acc) begin
            base_q    <= base_addr_i;
            issue_cnt <= CNT_W'(1);
         end else if (issue) begin
            issue_cnt <= issue_cnt + CNT_W'(1);
         end

         if (flush_req) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_cnt <= fifo_cnt + FCNT_W'(push) - FCNT_W'(pop);
         end

         if (start_acc || flush_req) begin
            row_q <= '0;
            col_q <= '0;
         end else if (pop) begin
            if (col_end) begin
               col_q <= '0;
               row_q <= (row_q == ROW_W'(IMG_ROWS - 1)) ? '0 : row_q + ROW_W'(1);
            end else begin
               col_q <= col_q + COL_W'(1);
            end
         end

         flush_cnt <= (state == S_FLUSH) ? flush_cnt + FL_W'(1) : '0;
      end
   end

   // Pixel storage needs no reset; m_data_o is masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= mem2d_i;
   end

`ifdef FETCH_STALL_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst_n)                                            stall_cnt_o <= '0;
      else if (start_acc)                                    stall_cnt_o <= '0;
      else if (m_valid_o && !m_ready_i && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 32'd1;
   end
`endif

endmodule

// File: tb/tb_bram_frame_fetcher.sv
// Directed bench for bram_frame_fetcher: 3x4 frames on an RD_LAT=2 instance (a) and an
// RD_LAT=4/FIFO_DEPTH=8 instance (b); each BRAM model returns addr[7:0].
module tb_bram_frame_fetcher;

   localparam int DEPTH_A = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int          n_checks = 0;
   int          n_errors = 0;

   logic        start_a = 0, abort_a = 0, ready_a = 0;
   logic [18:0] base_a = '0, addr_a;
   logic        busy_a, done_a, ena_a, wea_a, valid_a, eol_a, last_a;
   logic [7:0]  d2mem_a, mem2d_a, data_a;
   logic [1:0]  row_a, col_a;

   logic        start_b = 0, abort_b = 0, ready_b = 0;
   logic [18:0] base_b = '0, addr_b;
   logic        busy_b, done_b, ena_b, wea_b, valid_b, eol_b, last_b;
   logic [7:0]  d2mem_b, mem2d_b, data_b;
   logic [1:0]  row_b, col_b;
`ifdef FETCH_STALL_CNT_EN
   logic [31:0] stall_a, stall_b;
`endif

   always #5 clk = ~clk;

   bram_frame_fetcher #(.DATA_W(8), .ADDR_W(19), .IMG_ROWS(3), .IMG_COLS(4), .RD_LAT(2), .FIFO_DEPTH(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .start_i(start_a), .abort_i(abort_a), .base_addr_i(base_a),
      .busy_o(busy_a), .done_o(done_a), .ena_o(ena_a), .wea_o(wea_a), .addr_o(addr_a),
      .d2mem_o(d2mem_a), .mem2d_i(mem2d_a), .m_valid_o(valid_a), .m_ready_i(ready_a),
      .m_data_o(data_a), .m_row_o(row_a), .m_col_o(col_a), .m_eol_o(eol_a), .m_last_o(last_a)
`ifdef FETCH_STALL_CNT_EN
      , .stall_cnt_o(stall_a)
`endif
   );

   bram_frame_fetcher #(.DATA_W(8), .ADDR_W(19), .IMG_ROWS(3), .IMG_COLS(4), .RD_LAT(4), .FIFO_DEPTH(8)) dut_b (
      .clk(clk), .rst_n(rst_n), .start_i(start_b), .abort_i(abort_b), .base_addr_i(base_b),
      .busy_o(busy_b), .done_o(done_b), .ena_o(ena_b), .wea_o(wea_b), .addr_o(addr_b),
      .d2mem_o(d2mem_b), .mem2d_i(mem2d_b), .m_valid_o(valid_b), .m_ready_i(ready_b),
      .m_data_o(data_b), .m_row_o(row_b), .m_col_o(col_b), .m_eol_o(eol_b), .m_last_o(last_b)
`ifdef FETCH_STALL_CNT_EN
      , .stall_cnt_o(stall_b)
`endif
   );

   // BRAM models: address sampled on the edge after issue, data out RD_LAT cycles after issue.
   logic [7:0] pa [2];
   logic [7:0] pb [4];
   always_ff @(posedge clk) begin
      pa[0] <= addr_a[7:0];
      pa[1] <= pa[0];
      pb[0] <= addr_b[7:0];
      for (int i = 1; i < 4; i++) pb[i] <= pb[i-1];
   end
   assign mem2d_a = pa[1];
   assign mem2d_b = pb[3];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle_a(input string tag);
      check({tag, "_ctl"}, {25'd0, busy_a, done_a, ena_a, wea_a, valid_a, eol_a, last_a}, 32'd0);
      check({tag, "_addr"}, 32'(addr_a), 32'd0);
      check({tag, "_data"}, {16'd0, data_a, d2mem_a}, 32'd0);
      check({tag, "_rowcol"}, {28'd0, row_a, col_a}, 32'd0);
   endtask

   // Runs one frame on dut_a from IDLE. mode 0: ready held 1; mode 1: ready toggles (0 in start cycle).
   // inject_at: cycle of a spurious start while busy (-1 for none); abort0: abort with the start.
   task automatic run_frame(input int mode, input int inject_at, input bit abort0, input logic [18:0] base);
      int         c = 0, k = 0, issued = 0, stalls = 0, last_c = -10;
      bit         done_seen = 0, first_seen = 0, stalled = 0;
      logic [7:0] held = '0;
      while (!done_seen && c < 200) begin
         start_a = (c == 0) || (c == inject_at);
         base_a  = (c == 0) ? base : 19'h155;
         abort_a = abort0 && (c == 0);
         ready_a = (mode == 0) ? 1'b1 : c[0];
         #2;
         if (c == 1) check("busy_after_start", 32'(busy_a), 32'd1);
         if (ena_a) begin
            check("credit", 32'((issued - k - int'(valid_a && ready_a)) < DEPTH_A), 32'd1);
            check("addr", 32'(addr_a), 32'(19'(base + 19'(issued))));
            issued++;
         end
         if (stalled) begin
            check("hold_valid", 32'(valid_a), 32'd1);
            check("hold_data", 32'(data_a), 32'(held));
         end
         if (valid_a && !first_seen) begin
            first_seen = 1;
            check("first_valid_cycle", 32'(c), 32'd3);
         end
         if (valid_a && ready_a) begin
            check("data", 32'(data_a), 32'(k));
            check("row", 32'(row_a), 32'(k / 4));
            check("col", 32'(col_a), 32'(k % 4));
            check("eol", 32'(eol_a), 32'((k % 4) == 3));
            check("last", 32'(last_a), 32'(k == 11));
            if (mode == 0) check("hs_cycle", 32'(c), 32'(3 + k));
            k++;
            last_c = c;
         end
         if (done_a) begin
            done_seen = 1;
            check("done_cycle", 32'(c), 32'(last_c + 1));
            check("done_count", 32'(k), 32'd12);
            check("busy_at_done", 32'(busy_a), 32'd0);
`ifdef FETCH_STALL_CNT_EN
            check("stall_cnt", stall_a, 32'(stalls));
`endif
         end
         stalled = valid_a && !ready_a;
         held    = data_a;
         if (stalled) stalls++;
         @(posedge clk); #1;
         c++;
      end
      start_a = 1'b0;
      abort_a = 1'b0;
      check("frame_done", 32'(done_seen), 32'd1);
      check("issued", 32'(issued), 32'd12);
      #2;
      check("done_one_cycle", {30'd0, done_a, busy_a}, 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      int n, k;
      bit fin;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_idle_a("reset_a");
      check("reset_b", {24'd0, busy_b, done_b, ena_b, wea_b, valid_b, eol_b, last_b, |addr_b}, 32'd0);
`ifdef FETCH_STALL_CNT_EN
      check("reset_stall", stall_a, 32'd0);
`endif
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Streaming with ready held, then with ready toggling
      run_frame(0, -1, 1'b0, 19'h100);
      run_frame(1, -1, 1'b0, 19'h100);

      // Abort at the 5th issue
      start_a = 1'b1; base_a = 19'h100; ready_a = 1'b1; n = 0;
      for (int c = 0; c < 20; c++) begin
         #2;
         if (ena_a) n++;
         if (n == 5 && ena_a) begin
            abort_a = 1'b1;
            @(posedge clk); #1;
            abort_a = 1'b0;
            start_a = 1'b0;
            break;
         end
         @(posedge clk); #1;
         start_a = 1'b0;
      end
      check("abort_issue_count", 32'(n), 32'd5);
      for (int i = 0; i < 2; i++) begin
         #2;
         check("flush_state", {28'd0, busy_a, valid_a, ena_a, done_a}, 32'b1000);
         @(posedge clk); #1;
      end
      #2;
      check("after_flush", {29'd0, busy_a, valid_a, done_a}, 32'd0);
      @(posedge clk); #1;
      run_frame(0, -1, 1'b0, 19'h100);

      // Abort alone in IDLE is ignored
      abort_a = 1'b1;
      @(posedge clk); #1;
      abort_a = 1'b0;
      #2;
      check("abort_idle", {30'd0, busy_a, done_a}, 32'd0);
      @(posedge clk); #1;

      // Start+abort together in IDLE (start wins) and a spurious start while busy
      run_frame(0, 6, 1'b1, 19'h100);

      // Reset mid-frame
      start_a = 1'b1; base_a = 19'h100; ready_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      #2;
      check_idle_a("midreset");
      @(posedge clk); #1;
      run_frame(0, -1, 1'b0, 19'h100);

      // Deep latency instance with downstream stalled for 20 cycles
      start_b = 1'b1; base_b = 19'h100; ready_b = 1'b0; n = 0;
      for (int c = 0; c < 20; c++) begin
         #2;
         if (ena_b) n++;
         @(posedge clk); #1;
         start_b = 1'b0;
      end
      check("b_stalled_issues", 32'(n), 32'd8);
      check("b_stalled_valid", 32'(valid_b), 32'd1);
      ready_b = 1'b1; k = 0; fin = 0;
      for (int c = 0; c < 100 && !fin; c++) begin
         #2;
         if (ena_b) n++;
         if (valid_b) begin
            check("b_data", 32'(data_b), 32'(k));
            check("b_rowcol", {28'd0, row_b, col_b}, {28'd0, 2'(k / 4), 2'(k % 4)});
            check("b_last", 32'(last_b), 32'(k == 11));
            k++;
         end
         if (done_b) begin
            fin = 1;
            check("b_done_count", 32'(k), 32'd12);
         end
         @(posedge clk); #1;
      end
      check("b_frame_done", 32'(fin), 32'd1);
      check("b_total_issues", 32'(n), 32'd12);
      check("b_idle", {30'd0, busy_b, valid_b}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
